// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single unified memory port between instruction fetch and the
// mem-stage data path of the 5-stage core. One access is outstanding at a
// time; the data path wins ties because it belongs to the older instruction.
// A wait-cycle watchdog force-completes accesses that are never acknowledged.
//
// Ports
//   clk, rst          core clock, synchronous active-high reset
//   if_req_i/addr_i   fetch request (level) and pc
//   flush_i           discard the in-flight fetch result
//   if_inst_o/done_o  fetched instruction and 1-cycle completion pulse
//   dm_*_i            data request (level), we, address, byte enables, wdata
//   dm_rdata_o/done_o load data and 1-cycle completion pulse
//   ram_*_o           registered memory port (ce, we, addr, sel, wdata)
//   ram_data_i/ack_i  memory read data and completion
//   stall_o           {wb,mem,ex,id,if,pc} stall vector, bit0 = pc
//   bus_err_o         1-cycle pulse when the watchdog expires
module mem_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        flush_i,
  output logic [31:0] if_inst_o,
  output logic        if_done_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [3:0]  dm_sel_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_done_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_data_i,
  input  logic        ram_ack_i,
  output logic [5:0]  stall_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2
  } state_t;

  localparam bit             WDOG_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             discard_q;

  logic in_wait;
  logic ack;
  logic expired;
  logic finish;
  logic fetch_fin;
  logic data_fin;

  // An ack only counts while the strobe is up, so a late ack after reset or
  // after completion is ignored. The ack beats the watchdog in a tie.
  assign in_wait   = (state_q != IDLE);
  assign ack       = ram_ce_o & ram_ack_i;
  assign expired   = WDOG_EN & in_wait & ~ram_ack_i & (cnt_q == LAST_CNT);
  assign finish    = ack | expired;
  assign fetch_fin = (state_q == IF_WAIT) & finish;
  assign data_fin  = (state_q == DM_WAIT) & finish;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dm_req_i) begin
          state_d = DM_WAIT;
        end else if (if_req_i) begin
          state_d = IF_WAIT;
        end
      end
      IF_WAIT, DM_WAIT: begin
        if (finish) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: completion data is passed straight through from the RAM
  always_comb begin
    if_done_o  = fetch_fin & ~discard_q & ~flush_i;
    if_inst_o  = (if_done_o && ack) ? ram_data_i : 32'h0;
    dm_done_o  = data_fin;
    dm_rdata_o = (data_fin && ack) ? ram_data_i : 32'h0;
    bus_err_o  = expired;
    // A pending data access freezes everything up to mem; otherwise a pending
    // fetch holds pc and if_id. A flushed fetch no longer holds the front end.
    if (dm_req_i && !data_fin) begin
      stall_o = 6'b011111;
    end else if (if_req_i && !fetch_fin && !flush_i && !discard_q) begin
      stall_o = 6'b000011;
    end else begin
      stall_o = 6'b000000;
    end
  end

  // Memory port registers: loaded on issue, held while waiting, cleared on
  // completion so the port is quiet whenever no access is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_ce_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= 32'h0;
      ram_sel_o   <= 4'h0;
      ram_wdata_o <= 32'h0;
    end else if (state_q == IDLE) begin
      if (dm_req_i) begin
        ram_ce_o    <= 1'b1;
        ram_we_o    <= dm_we_i;
        ram_addr_o  <= dm_addr_i;
        ram_sel_o   <= dm_sel_i;
        ram_wdata_o <= dm_wdata_i;
      end else if (if_req_i) begin
        ram_ce_o    <= 1'b1;
        ram_we_o    <= 1'b0;
        ram_addr_o  <= if_addr_i;
        ram_sel_o   <= 4'b1111;
        ram_wdata_o <= 32'h0;
      end else begin
        ram_ce_o    <= 1'b0;
        ram_we_o    <= 1'b0;
        ram_addr_o  <= 32'h0;
        ram_sel_o   <= 4'h0;
        ram_wdata_o <= 32'h0;
      end
    end else if (finish) begin
      ram_ce_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= 32'h0;
      ram_sel_o   <= 4'h0;
      ram_wdata_o <= 32'h0;
    end
  end

  // Watchdog counter counts unacknowledged wait cycles of the current access
  always_ff @(posedge clk) begin
    if (rst || !in_wait || finish) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Discard flag: a flush seen while the fetch is launching or waiting
  // suppresses its completion pulse; cleared once back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      discard_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    discard_q <= ~dm_req_i & if_req_i & flush_i;
        IF_WAIT: discard_q <= finish ? 1'b0 : (discard_q | flush_i);
        default: discard_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_sel;
  logic [31:0] dm_wdata;
  logic [31:0] ram_data;
  logic        ram_ack;

  logic [31:0] if_inst;
  logic        if_done;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        ram_ce;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_wdata;
  logic [5:0]  stall;
  logic        bus_err;

  mem_port_arbiter #(.TIMEOUT(TO), .CNT_W(5)) u_dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .flush_i(flush),
    .if_inst_o(if_inst), .if_done_o(if_done),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_sel_i(dm_sel),
    .dm_wdata_i(dm_wdata), .dm_rdata_o(dm_rdata), .dm_done_o(dm_done),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_sel_o(ram_sel), .ram_wdata_o(ram_wdata),
    .ram_data_i(ram_data), .ram_ack_i(ram_ack),
    .stall_o(stall), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: at most one outstanding access with its
  // captured request, a count of unacknowledged wait cycles, and a flag
  // telling whether its fetch result has been flushed.
  bit          m_busy   = 1'b0;
  bit          m_is_dm  = 1'b0;
  bit          m_disc   = 1'b0;
  int          m_waited = 0;
  logic        m_we     = 1'b0;
  logic [31:0] m_addr   = 32'h0;
  logic [3:0]  m_sel    = 4'h0;
  logic [31:0] m_wdata  = 32'h0;

  logic        e_ack, e_exp, e_fin;
  logic        e_if_done, e_dm_done;
  logic [31:0] e_if_inst, e_dm_rdata;
  logic [5:0]  e_stall;

  always_comb begin
    e_ack      = m_busy && ram_ack;
    e_exp      = m_busy && !ram_ack && (TO != 0) && (m_waited == TO - 1);
    e_fin      = e_ack || e_exp;
    e_if_done  = m_busy && !m_is_dm && e_fin && !m_disc && !flush;
    e_if_inst  = (e_if_done && e_ack) ? ram_data : 32'h0;
    e_dm_done  = m_busy && m_is_dm && e_fin;
    e_dm_rdata = (e_dm_done && e_ack) ? ram_data : 32'h0;
    e_stall    = 6'b000000;
    if (dm_req && !e_dm_done)
      e_stall = 6'b011111;
    else if (if_req && !(m_busy && !m_is_dm && e_fin) && !flush && !m_disc)
      e_stall = 6'b000011;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_disc <= 1'b0; m_waited <= 0;
    end else if (m_busy) begin
      if (e_fin) begin
        m_busy <= 1'b0; m_disc <= 1'b0; m_waited <= 0;
      end else begin
        m_waited <= m_waited + 1;
        if (!m_is_dm && flush) m_disc <= 1'b1;
      end
    end else if (dm_req) begin
      m_busy <= 1'b1; m_is_dm <= 1'b1; m_we <= dm_we;
      m_addr <= dm_addr; m_sel <= dm_sel; m_wdata <= dm_wdata;
    end else if (if_req) begin
      m_busy <= 1'b1; m_is_dm <= 1'b0; m_we <= 1'b0;
      m_addr <= if_addr; m_sel <= 4'hF; m_wdata <= 32'h0; m_disc <= flush;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("ce",       32'(ram_ce),    32'(m_busy));
      check("we",       32'(ram_we),    m_busy ? 32'(m_we) : 32'h0);
      check("addr",     ram_addr,       m_busy ? m_addr : 32'h0);
      check("sel",      32'(ram_sel),   m_busy ? 32'(m_sel) : 32'h0);
      check("wdata",    ram_wdata,      m_busy ? m_wdata : 32'h0);
      check("if_done",  32'(if_done),   32'(e_if_done));
      check("if_inst",  if_inst,        e_if_inst);
      check("dm_done",  32'(dm_done),   32'(e_dm_done));
      check("dm_rdata", dm_rdata,       e_dm_rdata);
      check("bus_err",  32'(bus_err),   32'(e_exp));
      check("stall",    32'(stall),     32'(e_stall));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    if_req = 1'b0; if_addr = 32'h0; flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_sel = 4'h0; dm_wdata = 32'h0;
    ram_ack = 1'b0; ram_data = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    mid();
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_ce", 32'(ram_ce), 32'h0);
    check("rst_done", 32'(if_done | dm_done | bus_err), 32'h0);
    tick();
    rst = 1'b0;
    mid(); tick();

    // Load with zero-wait memory
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_sel = 4'hF;
    mid(); check("ld_stall_N", 32'(stall), 32'h1F); check("ld_ce_N", 32'(ram_ce), 32'h0);
    tick();
    ram_ack = 1'b1; ram_data = 32'hDEADBEEF;
    mid();
    check("ld_ce", 32'(ram_ce), 32'h1); check("ld_addr", ram_addr, 32'h100);
    check("ld_done", 32'(dm_done), 32'h1); check("ld_rdata", dm_rdata, 32'hDEADBEEF);
    check("ld_stall", 32'(stall), 32'h0);
    tick();
    idle(); mid(); check("ld_ce_after", 32'(ram_ce), 32'h0); tick();

    // Simultaneous fetch and store: store first
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_sel = 4'b0011; dm_wdata = 32'h12345678;
    mid(); check("st_stall_N", 32'(stall), 32'h1F); tick();
    mid(); check("st_we", 32'(ram_we), 32'h1); check("st_sel", 32'(ram_sel), 32'h3);
    check("st_wdata", ram_wdata, 32'h12345678); tick();
    ram_ack = 1'b1;
    mid(); check("st_done", 32'(dm_done), 32'h1); check("st_stall_done", 32'(stall), 32'h03); tick();
    dm_req = 1'b0; dm_we = 1'b0; ram_ack = 1'b0;
    mid(); check("fe_idle_ce", 32'(ram_ce), 32'h0); check("fe_idle_stall", 32'(stall), 32'h03); tick();
    mid(); check("fe_addr", ram_addr, 32'h80); check("fe_sel", 32'(ram_sel), 32'hF); tick();
    ram_ack = 1'b1; ram_data = 32'h00000013;
    mid(); check("fe_done", 32'(if_done), 32'h1); check("fe_inst", if_inst, 32'h13);
    check("fe_stall", 32'(stall), 32'h0); tick();
    idle(); mid(); tick();

    // Watchdog: fetch never acknowledged
    if_req = 1'b1; if_addr = 32'h40;
    mid(); tick();
    for (int w = 1; w <= TO; w++) begin
      if (w == TO) if_req = 1'b0;
      mid();
      check("wd_ce", 32'(ram_ce), 32'h1);
      check("wd_err", 32'(bus_err), (w == TO) ? 32'h1 : 32'h0);
      check("wd_done", 32'(if_done), (w == TO) ? 32'h1 : 32'h0);
      tick();
    end
    mid(); check("wd_ce_after", 32'(ram_ce), 32'h0); check("wd_err_after", 32'(bus_err), 32'h0);
    tick();

    // Flush during IF_WAIT
    if_req = 1'b1; if_addr = 32'h44;
    mid(); tick();
    mid(); check("fl_stall_wait", 32'(stall), 32'h03); tick();
    flush = 1'b1; if_req = 1'b0;
    mid(); check("fl_stall_flush", 32'(stall), 32'h0); tick();
    flush = 1'b0;
    mid(); tick();
    ram_ack = 1'b1; ram_data = 32'h24020005;
    mid(); check("fl_done", 32'(if_done), 32'h0); check("fl_inst", if_inst, 32'h0); tick();
    idle(); mid(); tick();

    // Flush in the cycle the fetch is launched, request held
    if_req = 1'b1; if_addr = 32'h48; flush = 1'b1;
    mid(); check("fle_stall_N", 32'(stall), 32'h0); tick();
    flush = 1'b0;
    mid(); check("fle_stall_w", 32'(stall), 32'h0); tick();
    ram_ack = 1'b1; ram_data = 32'h11111111; if_req = 1'b0;
    mid(); check("fle_done", 32'(if_done), 32'h0); tick();
    idle(); mid(); tick();

    // Reset in the middle of a data access
    dm_req = 1'b1; dm_addr = 32'h300; dm_sel = 4'hF;
    mid(); tick();
    mid(); check("rm_ce_wait", 32'(ram_ce), 32'h1); tick();
    rst = 1'b1; dm_req = 1'b0;
    mid(); tick();
    rst = 1'b0; ram_ack = 1'b1; ram_data = 32'hFFFFFFFF;
    mid();
    check("rm_ce", 32'(ram_ce), 32'h0); check("rm_done", 32'(dm_done), 32'h0);
    check("rm_rdata", dm_rdata, 32'h0); check("rm_stall", 32'(stall), 32'h0);
    tick();
    idle(); mid(); tick();

    // Ack on the last watchdog cycle wins over the timeout
    dm_req = 1'b1; dm_addr = 32'h104; dm_sel = 4'hF;
    mid(); tick();
    for (int w = 1; w <= TO; w++) begin
      if (w == TO) begin ram_ack = 1'b1; ram_data = 32'hCAFEF00D; end
      mid();
      check("at_done", 32'(dm_done), (w == TO) ? 32'h1 : 32'h0);
      if (w == TO) begin
        check("at_rdata", dm_rdata, 32'hCAFEF00D);
        check("at_err", 32'(bus_err), 32'h0);
      end
      tick();
    end
    idle(); mid(); tick();

    // Data request arriving during IF_WAIT
    if_req = 1'b1; if_addr = 32'h4C;
    mid(); tick();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h208; dm_sel = 4'hF; dm_wdata = 32'hA5A5A5A5;
    mid(); check("dr_stall_w", 32'(stall), 32'h1F); check("dr_we_fetch", 32'(ram_we), 32'h0); tick();
    ram_ack = 1'b1; ram_data = 32'h00000093;
    mid(); check("dr_if_done", 32'(if_done), 32'h1); check("dr_if_inst", if_inst, 32'h93);
    check("dr_stall_fin", 32'(stall), 32'h1F); tick();
    ram_ack = 1'b0; if_req = 1'b0;
    mid(); check("dr_idle_ce", 32'(ram_ce), 32'h0); check("dr_idle_stall", 32'(stall), 32'h1F); tick();
    ram_ack = 1'b1; ram_data = 32'h0;
    mid(); check("dr_addr", ram_addr, 32'h208); check("dr_dm_done", 32'(dm_done), 32'h1);
    check("dr_stall_done", 32'(stall), 32'h0); tick();
    idle(); mid(); tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single unified memory port between the instruction-fetch path (pc_reg/if_id) and the data-access path (mem stage) of the 5-stage core. It sequences each access with a request/ack handshake and generates the per-stage stall vector that freezes the pipeline while an access is outstanding. A wait-cycle watchdog terminates accesses that are never acknowledged.

Parameters:
TIMEOUT, 16, max cycles in a WAIT state before forced completion; 0 disables the watchdog
CNT_W, 5, watchdog counter width; must hold TIMEOUT

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
if_req_i  in  1  fetch request, level
if_addr_i  in  32  fetch address (pc)
flush_i  in  1  discard any in-flight fetch result
if_inst_o  out  32  fetched instruction, valid when if_done_o=1, else 0
if_done_o  out  1  fetch complete, 1-cycle pulse
dm_req_i  in  1  data request, level
dm_we_i  in  1  1=store, 0=load
dm_addr_i  in  32  data address
dm_sel_i  in  4  byte enables
dm_wdata_i  in  32  store data
dm_rdata_o  out  32  load data, valid when dm_done_o=1, else 0
dm_done_o  out  1  data access complete, 1-cycle pulse
ram_ce_o  out  1  memory access strobe (registered)
ram_we_o  out  1  write enable (registered)
ram_addr_o  out  32  address (registered)
ram_sel_o  out  4  byte enables (registered)
ram_wdata_o  out  32  write data (registered)
ram_data_i  in  32  memory read data
ram_ack_i  in  1  memory completion; sampled only while ram_ce_o=1
stall_o  out  6  {wb,mem,ex,id,if,pc} stall bits, bit0=pc
bus_err_o  out  1  1-cycle pulse on watchdog expiry

Behaviour:
- Reset: clk and rst are a single clock with synchronous, active-high reset. On rst=1 at a clock edge: state IDLE, all ram_* outputs 0, counter 0, discard flag 0. Combinational outputs are then 0: if_inst_o, dm_rdata_o, if_done_o, dm_done_o, bus_err_o, and stall_o=6'b000000. Reset mid-access abandons the access; any late ram_ack_i is ignored because ram_ce_o=0.
- States: IDLE, IF_WAIT, DM_WAIT.
- IDLE:
  - If dm_req_i=1, latch dm_* onto ram_* with ce=1 and go to DM_WAIT. Data has fixed priority over fetch because it belongs to the older instruction.
  - Else if if_req_i=1, latch if_addr_i, we=0, sel=4'b1111, ce=1, and go to IF_WAIT.
  - Else stay in IDLE with ce=0.
- WAIT states: ram_* are held stable. The counter increments every cycle with ram_ack_i=0.
  - On ram_ack_i=1: the done pulse and data (ram_data_i passed through combinationally) are presented in the same cycle. At that edge ce drops to 0, state returns to IDLE, and the counter clears.
- Watchdog: if TIMEOUT≠0 and counter==TIMEOUT-1 with no ack, the access force-completes. The done pulse fires with data 0 and bus_err_o=1 in that cycle, then the block returns to IDLE.
- Latency: a request seen in IDLE at cycle N drives ce from N+1. The earliest completion is N+1. Back-to-back accesses are separated by one IDLE cycle.
- Stall, combinational:
  - 6'b011111 while dm_req_i=1 and the data access is not completing this cycle (pending in IDLE, in DM_WAIT, or waiting behind an IF_WAIT).
  - Otherwise 6'b000011 while if_req_i=1 and the fetch is not completing this cycle. pc and if_id hold, and id receives a bubble.
  - Otherwise 6'b000000.
- Flush: flush_i=1 in IF_WAIT, or in the cycle IF_WAIT is entered, sets the discard flag. On the following ack, if_done_o stays 0 and if_inst_o=0. The flag clears on return to IDLE. The fetch stall is released from the flush cycle onward. Data accesses ignore flush_i.
- Simultaneous events:
  - dm_req_i rising during IF_WAIT: the fetch finishes first, then the data access is served from the next IDLE. The stall is 011111 throughout.
  - Ack and timeout in the same cycle: the ack wins and no error is raised.
  - Requests dropped mid-WAIT do not abort the access; the completion is delivered, and a requester that has dropped its request must ignore it.

Test Plan:
- Load, 0-wait memory: dm_req=1, we=0, addr=0x100, RAM returns 0xDEADBEEF with ack in the first ce cycle → ce at N+1, dm_done=1 and dm_rdata=0xDEADBEEF at N+1, stall=011111 at N only.
- Simultaneous fetch and store: if_req=1, dm_req=1, store 0x12345678 with sel=4'b0011 at 0x200, RAM ack after 2 cycles → store is issued first with ram_sel=0011, then the fetch from if_addr, done pulses in that order, stall 011111 then 000011.
- Watchdog: TIMEOUT=4, fetch at 0x40, ack never asserted → exactly 4 WAIT cycles, then if_done=1, if_inst=0, bus_err=1 for 1 cycle, ce=0 the next cycle.
- Flush: fetch in IF_WAIT, flush_i pulsed, ack 2 cycles later with 0x24020005 → if_done stays 0, if_inst=0, stall drops to 000000 after flush when if_req=0.
- Reset mid-access: rst=1 in DM_WAIT → next edge ce=0, stall=0, no done pulse; a late ram_ack_i=1 produces no output.
- Ack with timeout: TIMEOUT=3, ack in the 3rd WAIT cycle → done pulses with RAM data, bus_err=0.
